// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the data-memory request/response slave.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
endpackage

// File: rtl/wstrb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise keeps the old one.
module wstrb_merge
    import mem_bus_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] new_word,
    input  logic [STRB_W-1:0] strb,
    output logic [WORD_W-1:0] merged
);
    always_comb begin
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end
endmodule

// File: rtl/mem_resp_slave.sv
// Single-outstanding memory responder: accept, wait LATENCY edges, access the array, hold the response.
module mem_resp_slave
    import mem_bus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int IW = $clog2(MEM_WORDS);

    state_t            state;
    logic [LAT_W-1:0]  cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic [IW-1:0]     idx;
    logic              err;
    logic              access;
    logic [WORD_W-1:0] merged;

    assign idx       = addr_q[IW+1:2];
    assign err       = (addr_q[1:0] != 2'b00) || (addr_q[31:IW+2] != '0);
    assign access    = (state == WAIT) && (cnt == '0);
    assign req_ready = (state == IDLE);

    wstrb_merge u_merge (
        .old_word (mem[idx]),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

    // Array has no reset; an async reset pulls state out of WAIT so a pending write never commits.
    always_ff @(posedge clk) begin
        if (access && we_q && !err) mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        cnt     <= LAT_W'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LAT_W'(1);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (err || we_q) ? '0 : mem[idx];
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_resp_slave.sv
// Directed plus randomized bench for mem_resp_slave at LATENCY 2, 1 and 15 against a word-array model.
module tb_mem_resp_slave;
    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq_valid [3];
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_ready = 1'b1;

    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int lat [3] = '{2, 1, 15};
    logic [31:0] mdl [3][MEM_WORDS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp_slave #(.MEM_WORDS(MEM_WORDS), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rq_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]));
    mem_resp_slave #(.MEM_WORDS(MEM_WORDS), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rq_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]));
    mem_resp_slave #(.MEM_WORDS(MEM_WORDS), .LATENCY(15)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(rq_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Model: byte-addressed rules applied directly; returns expected rdata/err and updates the array.
    task automatic model(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] er, output logic ee);
        int wi;
        ee = (a % 4 != 0) || (a >= MEM_WORDS * 4);
        er = '0;
        wi = int'(a / 4) % MEM_WORDS;
        if (!ee) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) mdl[d][wi][8*b +: 8] = wd[8*b +: 8];
            end else begin
                er = mdl[d][wi];
            end
        end
    endtask

    // Caller sits at a negedge with the slave idle.
    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int hold);
        int n;
        logic [31:0] er;
        logic ee;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_we = we; req_addr = a; req_wdata = wd; req_wstrb = st;
        rq_valid[d] = 1'b1;
        @(negedge clk);
        rq_valid[d] = 1'b0;
        req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_wstrb = ~st;
        n = 0;
        chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        while (!resp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat[d]));
        model(d, we, a, wd, st, er, ee);
        chk("rdata", resp_rdata[d], er);
        chk("err", 32'(resp_err[d]), 32'(ee));
        if (hold > 0) begin
            resp_ready = 1'b0;
            rq_valid[d] = 1'b1;
            req_we = 1'b0; req_addr = 32'h40;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid[d]), 32'd1);
                chk("hold_rdata", resp_rdata[d], er);
                chk("hold_err", 32'(resp_err[d]), 32'(ee));
                chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
            end
            rq_valid[d] = 1'b0;
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_valid", 32'(resp_valid[d]), 32'd0);
        chk("post_rdata", resp_rdata[d], 32'd0);
        chk("post_err", 32'(resp_err[d]), 32'd0);
        chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
            chk({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
            chk({tag, "_resp_rdata"}, resp_rdata[d], 32'd0);
            chk({tag, "_resp_err"}, 32'(resp_err[d]), 32'd0);
        end
    endtask

    initial begin
        int n;
        int r;
        logic [31:0] a;
        logic [31:0] er;
        logic ee;
        for (int d = 0; d < 3; d++) begin
            rq_valid[d] = 1'b0;
            for (int w = 0; w < MEM_WORDS; w++) mdl[d][w] = 'x;
        end

        #1 chk_reset_outs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("merged_word", mdl[0][4], 32'hDE22BE44);
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h14, 32'h99999999, 4'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Reset while a write is still waiting: array must keep the prior word.
        txn(0, 1'b1, 32'h20, 32'h01020304, 4'hF, 0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        rq_valid[0] = 1'b1;
        @(negedge clk);
        rq_valid[0] = 1'b0;
        reset = 1'b1;
        #1 chk_reset_outs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Reset while in RESP: the write already happened.
        req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'hF;
        rq_valid[0] = 1'b1;
        @(negedge clk);
        rq_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("commit_latency", 32'(n), 32'd2);
        model(0, 1'b1, 32'h24, 32'hA5A5A5A5, 4'hF, er, ee);
        reset = 1'b1;
        #1 chk("commit_reset_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0);

        for (int d = 1; d < 3; d++) begin
            txn(d, 1'b1, 32'h4, 32'h600DF00D, 4'hF, 0);
            txn(d, 1'b0, 32'h4, 32'h0, 4'h0, 0);
            txn(d, 1'b0, 32'h6, 32'h0, 4'h0, 0);
        end

        for (int w = 0; w < 16; w++) txn(0, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 15) * 4);
            else if (r == 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 15) * 4);
            txn(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
